// File: rtl/sr_latch_driver.sv
// sr_latch_driver: drives timed, mutually exclusive S/R pulses into an SR flip-flop and confirms Q.
// Optional: define SR_SKIP_REDUNDANT_EN to finish at once when Q already holds the requested level.
module sr_latch_driver #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic q_fb,
    output logic busy,
    output logic done,
    output logic err
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP, CHECK} state_t;

    localparam logic [7:0] PULSE_LD = 8'(PULSE_W - 1);
    localparam logic [7:0] GAP_LD   = 8'((GAP_W == 0) ? 0 : GAP_W - 1);
    localparam logic [7:0] TO_LD    = 8'(TIMEOUT - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       target_q;
    logic       s_q;
    logic       r_q;
    logic       busy_q;
    logic       done_q;
    logic       err_q;
    logic       redundant;

`ifdef SR_SKIP_REDUNDANT_EN
    assign redundant = (req_level == q_fb);
`else
    assign redundant = 1'b0;
`endif

    assign req_ready = (state_q == IDLE);
    assign S         = s_q;
    assign R         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

    // Counters hold "remaining cycles minus one" so a zero test marks the last cycle of a state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            target_q <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        target_q <= req_level;
                        if (redundant) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= PULSE;
                            cnt_q   <= PULSE_LD;
                            s_q     <= req_level;
                            r_q     <= ~req_level;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                PULSE: begin
                    if (cnt_q == 8'd0) begin
                        s_q <= 1'b0;
                        r_q <= 1'b0;
                        if (GAP_W == 0) begin
                            state_q <= CHECK;
                            cnt_q   <= TO_LD;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= GAP_LD;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= CHECK;
                        cnt_q   <= TO_LD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                CHECK: begin
                    if (q_fb == target_q) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == 8'd0) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
Initiator-side controller for an SR flip-flop. It accepts a requested target level over a valid/ready handshake and drives timed, mutually exclusive set and reset pulses onto the flip-flop's S/R inputs. It then reads back the flip-flop's Q to confirm the write, and reports done or a timeout error. It sits between control logic and any SR storage element in the design.

Parameters:
PULSE_W, 2, cycles S or R is held high (1..255)
GAP_W, 1, recovery cycles with S=R=0 after the pulse (0..255; 0 skips GAP)
TIMEOUT, 8, max CHECK cycles waiting for q_fb to match the target (1..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_level  input  1  target level (1 = set, 0 = reset)
req_ready  output  1  block can accept a request (high only in IDLE)
S  output  1  set drive to the flip-flop
R  output  1  reset drive to the flip-flop
q_fb  input  1  Q readback from the flip-flop, synchronous to clk
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle pulse: write confirmed
err  output  1  one-cycle pulse: confirmation timeout

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state and outputs are registered except req_ready, which equals (state==IDLE).
- Reset values: state=IDLE, S=0, R=0, busy=0, done=0, err=0, req_ready=1, counters=0, target=0. Asserting rst_n mid-operation drops S/R immediately, with no clock edge needed.
- States: IDLE, PULSE, GAP, CHECK.
- IDLE: a request is accepted on an edge where req_valid & req_ready. On acceptance, target<=req_level and the state goes to PULSE. When not in IDLE, req_valid is ignored and its request is not queued.
- PULSE: S=target and R=~target for exactly PULSE_W cycles, starting the cycle after acceptance. Then the state goes to GAP, or to CHECK if GAP_W=0.
- GAP: S=R=0 for exactly GAP_W cycles, then the state goes to CHECK.
- CHECK: S=R=0. q_fb is sampled each edge.
  - If q_fb==target: done=1 for the next cycle and the state goes to IDLE.
  - If no match has been sampled after TIMEOUT CHECK edges: err=1 for the next cycle and the state goes to IDLE.
- Latency with acceptance at edge e0: done is high in the cycle after edge e0+PULSE_W+GAP_W+1. With defaults, done rises 4 cycles after acceptance.
- A new request may be accepted in the same cycle done or err is high, giving back-to-back operation.
- Invariants:
  - S and R are never both 1.
  - done and err are never both 1.
  - done and err are never high for two consecutive cycles from a single request.
- Counters are 8 bits wide. Each counter reloads on entry to its state and never wraps.

Optional Feature:
Macro SR_SKIP_REDUNDANT_EN.
- Defined: if req_level==q_fb on the acceptance edge, no pulse is issued. done=1 in the next cycle, the state stays IDLE, and busy stays 0.
- Undefined: every accepted request runs the full PULSE/GAP/CHECK sequence regardless of q_fb.

Test Plan:
- Reset: hold rst_n=0 with req_valid=1 -> S=R=busy=done=err=0 and req_ready=1. After release and the first edge, the request is accepted.
- Set, with a behavioural SR flip-flop model closing the loop and defaults, req_level=1 accepted at edge 0 -> S=1 for cycles 1-2, S=R=0 in cycle 3, done=1 in cycle 4 only, q_fb=1, R never 1.
- Reset request from Q=1, req_level=0 -> R=1 for 2 cycles and S stays 0. done arrives 4 cycles after acceptance.
- Timeout: q_fb tied 0 and req_level=1 -> after PULSE and GAP, 8 CHECK cycles pass, then err=1 for one cycle, done=0, and req_ready=1 again.
- Handshake: req_valid held high continuously with alternating levels -> a new acceptance occurs only in the cycle where done is high. Requests during busy are dropped, and pulses alternate S, R, S.
- Reset mid-PULSE: rst_n drops in cycle 1 of an S pulse -> S falls asynchronously and the state is IDLE after release. With SR_SKIP_REDUNDANT_EN defined and q_fb=1, a req_level=1 request -> done next cycle, no S pulse.
